// File: rtl/data_path_mc_if.sv
// Memory request/response bus between the multi-cycle datapath (master) and a
// variable-latency RAM (slave).
interface data_path_mc_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/data_path_mc.sv
// Multi-cycle CPU datapath: register file, ALU + flags, PC, IR and a handshaked
// memory port. Executes one EXEC/FETCH/LOAD/STORE command at a time.
module data_path_mc #(
  parameter int                DATA_W      = 16,
  parameter int                NREG        = 16,
  parameter int                ADDR_W      = 16,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                MEM_TIMEOUT = 255,
  localparam int               RW          = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_start,
  input  logic [1:0]        op_kind,
  input  logic [RW-1:0]     rdest_sel,
  input  logic [RW-1:0]     rsrc_sel,
  input  logic [DATA_W-1:0] imm,
  input  logic              imm_sel,
  input  logic [3:0]        alu_op,
  input  logic              wb_en,
  input  logic              flags_en,
  input  logic [1:0]        pc_mode,
  input  logic [ADDR_W-1:0] disp,
  data_path_mc_if.master    mem,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       ir,
  output logic [4:0]        flags
);

  localparam int SW = $clog2(DATA_W) + 1;
  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  localparam int FC = 4, FL = 3, FF = 2, FZ = 1, FN = 0;
  localparam logic [1:0] K_EXEC = 2'b00, K_FETCH = 2'b01, K_LOAD = 2'b10, K_STORE = 2'b11;

  typedef enum logic [1:0] {IDLE, MEM, DONE} state_t;
  state_t state, state_nxt;

  logic [DATA_W-1:0] regs [NREG];
  logic [DATA_W-1:0] a_val, b_val, rsrc_val, alu_res;
  logic [DATA_W:0]   sum;
  logic [SW-1:0]     sh_amt;
  logic [SW:0]       sh_ext, sh_mag;
  logic [4:0]        alu_flags;
  logic              alu_wr, alu_valid, mem_timeout, req;
  logic [1:0]        cmd_kind;
  logic [RW-1:0]     cmd_rdest;
  logic [TW-1:0]     wait_cnt;
  logic [ADDR_W-1:0] addr_q, pc_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q, err_q;
  logic [15:0]       ir_q;
  logic [4:0]        flags_q;

  assign rsrc_val = regs[rsrc_sel];
  assign a_val    = regs[rdest_sel];
  assign b_val    = imm_sel ? imm : rsrc_val;

  // N and L survive every op except CMP; C and F are cleared by anything but ADD/SUB.
  always_comb begin
    alu_res   = '0;
    alu_flags = flags_q;
    alu_wr    = 1'b1;
    alu_valid = 1'b1;
    sum       = '0;
    sh_amt    = b_val[SW-1:0];
    sh_ext    = {sh_amt[SW-1], sh_amt};
    sh_mag    = sh_ext[SW] ? (~sh_ext + (SW+1)'(1)) : sh_ext;
    case (alu_op)
      4'd0: begin
        sum           = {1'b0, a_val} + {1'b0, b_val};
        alu_res       = sum[DATA_W-1:0];
        alu_flags[FC] = sum[DATA_W];
        alu_flags[FF] = (a_val[DATA_W-1] == b_val[DATA_W-1]) && (alu_res[DATA_W-1] != a_val[DATA_W-1]);
        alu_flags[FZ] = (alu_res == '0);
      end
      4'd1: begin
        sum           = {1'b0, a_val} - {1'b0, b_val};
        alu_res       = sum[DATA_W-1:0];
        alu_flags[FC] = sum[DATA_W];
        alu_flags[FF] = (a_val[DATA_W-1] != b_val[DATA_W-1]) && (alu_res[DATA_W-1] != a_val[DATA_W-1]);
        alu_flags[FZ] = (alu_res == '0);
      end
      4'd2: begin
        alu_wr        = 1'b0;
        alu_flags[FC] = 1'b0;
        alu_flags[FF] = 1'b0;
        alu_flags[FZ] = (a_val == b_val);
        alu_flags[FL] = (a_val < b_val);
        alu_flags[FN] = ($signed(a_val) < $signed(b_val));
      end
      4'd3, 4'd4, 4'd5: begin
        if (alu_op == 4'd3)      alu_res = a_val & b_val;
        else if (alu_op == 4'd4) alu_res = a_val | b_val;
        else                     alu_res = a_val ^ b_val;
        alu_flags[FC] = 1'b0;
        alu_flags[FF] = 1'b0;
        alu_flags[FZ] = (alu_res == '0);
      end
      4'd6: begin
        alu_res       = b_val;
        alu_flags[FC] = 1'b0;
        alu_flags[FF] = 1'b0;
      end
      4'd7: begin
        if (sh_mag >= (SW+1)'(DATA_W)) alu_res = '0;
        else if (sh_ext[SW])           alu_res = a_val >> sh_mag;
        else                           alu_res = a_val << sh_mag;
        alu_flags[FC] = 1'b0;
        alu_flags[FF] = 1'b0;
      end
      4'd8: begin
        alu_res       = b_val << (DATA_W - 8);
        alu_flags[FC] = 1'b0;
        alu_flags[FF] = 1'b0;
      end
      default: begin
        alu_wr    = 1'b0;
        alu_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    mem_timeout = 1'b0;
    req         = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (op_start) state_nxt = (op_kind == K_EXEC) ? DONE : MEM;
      end
      MEM: begin
        req = 1'b1;
        if (mem.mem_ack) begin
          state_nxt = DONE;
        end else if (wait_cnt == TW'(MEM_TIMEOUT - 1)) begin
          mem_timeout = 1'b1;
          state_nxt   = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Commands are latched at accept so the bus stays stable while memory stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      flags_q   <= '0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      cmd_kind  <= K_EXEC;
      cmd_rdest <= '0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        IDLE: if (op_start) begin
          cmd_kind  <= op_kind;
          cmd_rdest <= rdest_sel;
          wait_cnt  <= '0;
          if (op_kind == K_EXEC) begin
            if (wb_en && alu_wr)      regs[rdest_sel] <= alu_res;
            if (flags_en && alu_valid) flags_q        <= alu_flags;
            case (pc_mode)
              2'b01:   pc_q <= pc_q + ADDR_W'(1);
              2'b10:   pc_q <= pc_q + disp;
              2'b11:   pc_q <= rsrc_val[ADDR_W-1:0];
              default: pc_q <= pc_q;
            endcase
          end else begin
            addr_q  <= (op_kind == K_FETCH) ? pc_q : rsrc_val[ADDR_W-1:0];
            we_q    <= (op_kind == K_STORE);
            wdata_q <= a_val;
          end
        end
        MEM: begin
          if (mem.mem_ack) begin
            if (cmd_kind == K_FETCH) begin
              ir_q <= mem.mem_rdata[15:0];
              pc_q <= pc_q + ADDR_W'(1);
            end else if (cmd_kind == K_LOAD) begin
              regs[cmd_rdest] <= mem.mem_rdata;
            end
          end else if (mem_timeout) begin
            err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign mem.mem_req   = req;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign err   = err_q;
  assign pc    = pc_q;
  assign ir    = ir_q;
  assign flags = flags_q;

endmodule

// File: tb/tb_data_path_mc.sv
// Self-checking bench for data_path_mc: directed scenarios followed by random
// commands, all checked against an arithmetic reference model.
module tb_data_path_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_start;
  logic [1:0]  op_kind;
  logic [3:0]  rdest_sel, rsrc_sel;
  logic [15:0] imm;
  logic        imm_sel;
  logic [3:0]  alu_op;
  logic        wb_en, flags_en;
  logic [1:0]  pc_mode;
  logic [15:0] disp;
  logic        busy, done, err;
  logic [15:0] pc, ir;
  logic [4:0]  flags;

  logic [15:0] m_regs [16];
  logic [15:0] m_pc, m_ir;
  logic [4:0]  m_flags;
  logic        m_err;
  logic [15:0] mem_model [int];
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  data_path_mc_if #(.DATA_W(16), .ADDR_W(16)) mem_bus ();

  data_path_mc #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .op_start(op_start), .op_kind(op_kind),
    .rdest_sel(rdest_sel), .rsrc_sel(rsrc_sel), .imm(imm), .imm_sel(imm_sel),
    .alu_op(alu_op), .wb_en(wb_en), .flags_en(flags_en), .pc_mode(pc_mode),
    .disp(disp), .mem(mem_bus), .busy(busy), .done(done), .err(err),
    .pc(pc), .ir(ir), .flags(flags)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [1:0] kind, input logic [3:0] rd, input logic [3:0] rs,
                                input logic [15:0] imm_v, input logic isel, input logic [3:0] op,
                                input logic wb, input logic fl, input logic [1:0] pcm, input logic [15:0] dsp);
    op_kind = kind; rdest_sel = rd; rsrc_sel = rs; imm = imm_v; imm_sel = isel;
    alu_op = op; wb_en = wb; flags_en = fl; pc_mode = pcm; disp = dsp;
    op_start = 1'b1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 16'h0;
    m_pc = 16'h0; m_ir = 16'h0; m_flags = 5'b0; m_err = 1'b0;
  endtask

  // Reference EXEC semantics computed with plain integer arithmetic.
  task automatic model_exec(input logic [3:0] rd, input logic [3:0] rs, input logic [15:0] imm_v,
                            input logic isel, input logic [3:0] op, input logic wb, input logic fl,
                            input logic [1:0] pcm, input logic [15:0] dsp);
    int ua, ub, sa, sb, r, s;
    bit c, l, f, z, n, writes, touches;
    logic [15:0] rs_val;
    rs_val = m_regs[rs];
    ua = int'(m_regs[rd]);
    ub = isel ? int'(imm_v) : int'(rs_val);
    sa = (ua >= 32768) ? ua - 65536 : ua;
    sb = (ub >= 32768) ? ub - 65536 : ub;
    {c, l, f, z, n} = m_flags;
    r = 0; writes = 1'b1; touches = 1'b1;
    case (op)
      4'd0: begin r = ua + ub; c = (r > 65535); f = (sa + sb > 32767) || (sa + sb < -32768);
                  r = r & 32'hFFFF; z = (r == 0); end
      4'd1: begin r = (ua - ub) & 32'hFFFF; c = (ua < ub); f = (sa - sb > 32767) || (sa - sb < -32768);
                  z = (r == 0); end
      4'd2: begin writes = 1'b0; c = 1'b0; f = 1'b0; z = (ua == ub); l = (ua < ub); n = (sa < sb); end
      4'd3: begin r = ua & ub; c = 1'b0; f = 1'b0; z = (r == 0); end
      4'd4: begin r = ua | ub; c = 1'b0; f = 1'b0; z = (r == 0); end
      4'd5: begin r = ua ^ ub; c = 1'b0; f = 1'b0; z = (r == 0); end
      4'd6: begin r = ub; c = 1'b0; f = 1'b0; end
      4'd7: begin
        s = ub % 32;
        if (s >= 16) s = s - 32;
        if (s >= 16 || s <= -16) r = 0;
        else if (s >= 0)         r = (ua << s) & 32'hFFFF;
        else                     r = ua >> (-s);
        c = 1'b0; f = 1'b0;
      end
      4'd8: begin r = (ub << 8) & 32'hFFFF; c = 1'b0; f = 1'b0; end
      default: begin writes = 1'b0; touches = 1'b0; end
    endcase
    if (pcm == 2'b01)      m_pc = m_pc + 16'd1;
    else if (pcm == 2'b10) m_pc = m_pc + dsp;
    else if (pcm == 2'b11) m_pc = rs_val;
    if (wb && writes) m_regs[rd] = r[15:0];
    if (fl && touches) m_flags = {c, l, f, z, n};
  endtask

  task automatic exec_cmd(input logic [3:0] rd, input logic [3:0] rs, input logic [15:0] imm_v,
                          input logic isel, input logic [3:0] op, input logic wb, input logic fl,
                          input logic [1:0] pcm, input logic [15:0] dsp, input string tag);
    apply_stimulus(2'b00, rd, rs, imm_v, isel, op, wb, fl, pcm, dsp);
    mem_bus.mem_ack = 1'b1;
    mem_bus.mem_rdata = 16'($urandom);
    model_exec(rd, rs, imm_v, isel, op, wb, fl, pcm, dsp);
    @(posedge clk); #1;
    op_start = 1'b0; mem_bus.mem_ack = 1'b0;
    check_output({tag, "_done"}, 32'(done), 32'd1);
    check_output({tag, "_pc"}, 32'(pc), 32'(m_pc));
    check_output({tag, "_flags"}, 32'(flags), 32'(m_flags));
    check_output({tag, "_err"}, 32'(err), 32'(m_err));
    @(posedge clk); #1;
    check_output({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
  endtask

  // ack_wait: MEM cycle index at which ack is raised; out of 0..3 means never (timeout).
  task automatic do_mem(input logic [1:0] kind, input logic [3:0] rd, input logic [3:0] rs,
                        input int ack_wait, input logic [15:0] rdata, input bit poke, input string tag);
    logic [15:0] exp_addr, exp_wdata, rd_val;
    int req_cycles, exp_cycles;
    bit timed_out;
    exp_addr  = (kind == 2'b01) ? m_pc : m_regs[rs];
    exp_wdata = m_regs[rd];
    rd_val    = mem_model.exists(int'(exp_addr)) ? mem_model[int'(exp_addr)] : rdata;
    timed_out = (ack_wait < 0) || (ack_wait > 3);
    exp_cycles = timed_out ? 4 : ack_wait + 1;
    apply_stimulus(kind, rd, rs, 16'($urandom), 1'b0, 4'd6, 1'b1, 1'b1, 2'b01, 16'h0003);
    @(posedge clk); #1;
    op_start = 1'b0;
    req_cycles = 0;
    for (int k = 0; k < 64 && mem_bus.mem_req; k++) begin
      if (k == 0) begin
        check_output({tag, "_addr"}, 32'(mem_bus.mem_addr), 32'(exp_addr));
        check_output({tag, "_we"}, 32'(mem_bus.mem_we), 32'(kind == 2'b11));
        check_output({tag, "_wdata"}, 32'(mem_bus.mem_wdata), 32'(exp_wdata));
      end
      mem_bus.mem_ack   = (k == ack_wait);
      mem_bus.mem_rdata = (k == ack_wait) ? rd_val : 16'($urandom);
      if (poke) apply_stimulus(2'b00, 4'($urandom), 4'($urandom), 16'($urandom), 1'b1, 4'd6,
                               1'b1, 1'b1, 2'b01, 16'h0);
      req_cycles++;
      @(posedge clk); #1;
      mem_bus.mem_ack = 1'b0; op_start = 1'b0;
    end
    if (timed_out) m_err = 1'b1;
    else if (kind == 2'b01) begin m_ir = rd_val; m_pc = m_pc + 16'd1; end
    else if (kind == 2'b10) m_regs[rd] = rd_val;
    else mem_model[int'(exp_addr)] = exp_wdata;
    check_output({tag, "_req_cycles"}, 32'(req_cycles), 32'(exp_cycles));
    check_output({tag, "_done"}, {30'd0, busy, done}, 32'd3);
    check_output({tag, "_err"}, 32'(err), 32'(m_err));
    check_output({tag, "_pc"}, 32'(pc), 32'(m_pc));
    check_output({tag, "_ir"}, 32'(ir), 32'(m_ir));
    check_output({tag, "_flags"}, 32'(flags), 32'(m_flags));
    @(posedge clk); #1;
    check_output({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
  endtask

  task automatic read_reg(input logic [3:0] r, input string tag);
    do_mem(2'b11, r, 4'd0, 0, 16'h0, 1'b0, tag);
  endtask

  task automatic do_reset();
    reset = 1'b0; op_start = 1'b0; mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = 16'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
  endtask

  initial begin
    apply_stimulus(2'b00, 4'd0, 4'd0, 16'h0, 1'b0, 4'd15, 1'b0, 1'b0, 2'b00, 16'h0);
    op_start = 1'b0;
    do_reset();
    $display("[TB] reset released");
    check_output("rst_pc", 32'(pc), 32'h0);
    check_output("rst_status", {27'd0, busy, done, err, mem_bus.mem_req, mem_bus.mem_we}, 32'd0);
    check_output("rst_ir_flags", {11'd0, ir, flags}, 32'd0);
    read_reg(4'd3, "rst_r3");

    exec_cmd(4'd3, 4'd0, 16'h1234, 1'b1, 4'd6, 1'b1, 1'b0, 2'b00, 16'h0, "mov_r3");
    read_reg(4'd3, "r3_val");

    exec_cmd(4'd1, 4'd0, 16'hFFFF, 1'b1, 4'd6, 1'b1, 1'b0, 2'b00, 16'h0, "mov_r1");
    exec_cmd(4'd2, 4'd0, 16'h0001, 1'b1, 4'd6, 1'b1, 1'b0, 2'b00, 16'h0, "mov_r2");
    exec_cmd(4'd1, 4'd2, 16'h0, 1'b0, 4'd0, 1'b1, 1'b1, 2'b00, 16'h0, "add_wrap");
    check_output("add_flags_czf", {29'd0, flags[4], flags[1], flags[2]}, 32'b110);
    read_reg(4'd1, "add_r1");

    exec_cmd(4'd8, 4'd0, 16'h8000, 1'b1, 4'd6, 1'b1, 1'b0, 2'b00, 16'h0, "mov_r8");
    exec_cmd(4'd9, 4'd0, 16'h0001, 1'b1, 4'd6, 1'b1, 1'b0, 2'b00, 16'h0, "mov_r9");
    exec_cmd(4'd8, 4'd9, 16'h0, 1'b0, 4'd2, 1'b1, 1'b1, 2'b00, 16'h0, "cmp");
    check_output("cmp_flags_lnz", {29'd0, flags[3], flags[0], flags[1]}, 32'b010);
    read_reg(4'd8, "cmp_r8");

    exec_cmd(4'd10, 4'd0, 16'h0005, 1'b1, 4'd6, 1'b1, 1'b0, 2'b00, 16'h0, "mov_r10");
    exec_cmd(4'd0, 4'd10, 16'h0, 1'b0, 4'd15, 1'b0, 1'b0, 2'b11, 16'h0, "pc_load5");
    do_mem(2'b01, 4'd0, 4'd0, 3, 16'hA5C3, 1'b1, "fetch");
    check_output("fetch_ir_pc", {ir, pc}, {16'hA5C3, 16'h0006});

    exec_cmd(4'd4, 4'd0, 16'hBEEF, 1'b1, 4'd6, 1'b1, 1'b0, 2'b00, 16'h0, "mov_r4");
    exec_cmd(4'd5, 4'd0, 16'h0040, 1'b1, 4'd6, 1'b1, 1'b0, 2'b00, 16'h0, "mov_r5");
    do_mem(2'b11, 4'd4, 4'd5, 0, 16'h0, 1'b0, "store");
    do_mem(2'b10, 4'd6, 4'd5, 1, 16'h0, 1'b0, "load");
    read_reg(4'd6, "load_r6");

    exec_cmd(4'd11, 4'd0, 16'h1111, 1'b1, 4'd6, 1'b1, 1'b0, 2'b00, 16'h0, "mov_r11");
    do_mem(2'b10, 4'd11, 4'd5, -1, 16'h2222, 1'b1, "timeout");
    read_reg(4'd11, "timeout_r11");
    exec_cmd(4'd0, 4'd0, 16'h0, 1'b1, 4'd15, 1'b0, 1'b0, 2'b00, 16'h0, "err_sticky");

    // Reset mid-MEM: request must vanish immediately and a late ack is ignored.
    exec_cmd(4'd7, 4'd0, 16'h7777, 1'b1, 4'd6, 1'b1, 1'b0, 2'b00, 16'h0, "mov_r7");
    apply_stimulus(2'b10, 4'd7, 4'd5, 16'h0, 1'b0, 4'd6, 1'b0, 1'b0, 2'b00, 16'h0);
    @(posedge clk); #1;
    op_start = 1'b0;
    @(posedge clk); #1;
    check_output("rstmem_req_before", 32'(mem_bus.mem_req), 32'd1);
    reset = 1'b0;
    #1;
    check_output("rstmem_req_async", {30'd0, mem_bus.mem_req, busy}, 32'd0);
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 16'h5555;
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    mem_bus.mem_ack = 1'b0;
    check_output("rstmem_quiet", {29'd0, busy, done, err}, 32'd0);
    read_reg(4'd7, "rstmem_r7");

    exec_cmd(4'd1, 4'd0, 16'h0001, 1'b1, 4'd6, 1'b1, 1'b0, 2'b00, 16'h0, "mov_lsh_a");
    exec_cmd(4'd1, 4'd0, 16'h001F, 1'b1, 4'd7, 1'b1, 1'b0, 2'b00, 16'h0, "lsh_m1");
    read_reg(4'd1, "lsh_m1_r1");
    exec_cmd(4'd1, 4'd0, 16'h0001, 1'b1, 4'd6, 1'b1, 1'b0, 2'b00, 16'h0, "mov_lsh_b");
    exec_cmd(4'd1, 4'd0, 16'h0004, 1'b1, 4'd7, 1'b1, 1'b0, 2'b00, 16'h0, "lsh_p4");
    read_reg(4'd1, "lsh_p4_r1");

    exec_cmd(4'd12, 4'd0, 16'h0001, 1'b1, 4'd6, 1'b1, 1'b0, 2'b00, 16'h0, "mov_r12");
    exec_cmd(4'd0, 4'd12, 16'h0, 1'b0, 4'd15, 1'b0, 1'b0, 2'b11, 16'h0, "pc_load1");
    exec_cmd(4'd0, 4'd0, 16'h0, 1'b0, 4'd15, 1'b0, 1'b0, 2'b10, 16'hFFFE, "pc_disp");
    check_output("pc_wrap", 32'(pc), 32'hFFFF);

    $display("[TB] random phase");
    for (int i = 0; i < 60; i++) begin
      logic [1:0] kind;
      kind = 2'($urandom_range(0, 3));
      if (kind == 2'b00)
        exec_cmd(4'($urandom), 4'($urandom), 16'($urandom), 1'($urandom), 4'($urandom_range(0, 15)),
                 1'($urandom), 1'($urandom), 2'($urandom), 16'($urandom), "rnd_exec");
      else
        do_mem(kind, 4'($urandom), 4'($urandom), int'($urandom_range(0, 3)), 16'($urandom),
               1'($urandom), "rnd_mem");
    end
    for (int r = 0; r < 16; r++) read_reg(4'(r), "final_reg");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
